// File: rtl/xe1ap_pkg.sv
// xe1ap_pkg: shared state type, nibble layout and button bit positions
// for the XE-1AP host reader and device emulator.
package xe1ap_pkg;
    typedef enum logic [2:0] {IDLE, REQ_LOW, WAIT, SAMPLE, CHECK} state_t;
    localparam int NIBBLES = 12;
    localparam int N_BTN1 = 0, N_BTN2 = 1, N_CH0H = 2, N_CH1H = 3, N_CH2H = 4, N_RSV1 = 5;
    localparam int N_CH0L = 6, N_CH1L = 7, N_CH2L = 8, N_RSV2 = 9, N_AB = 10, N_END = 11;
    localparam int B_A = 7, B_B = 6, B_C = 5, B_D = 4, B_E1 = 3, B_E2 = 2, B_START = 1, B_SELECT = 0;
    function automatic logic [3:0] nib(input logic [4*NIBBLES-1:0] s, input int i);
        return s[4*i +: 4];
    endfunction
endpackage

// File: rtl/xe1ap_usec_timer.sv
// xe1ap_usec_timer: clk_sys-to-microsecond prescaler plus a microsecond
// counter, both cleared synchronously by clr; hit compares against limit.
module xe1ap_usec_timer #(
    parameter int CLKPERUSEC = 50,
    parameter int W = 10
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tick,
    output logic [W-1:0] count,
    output logic         hit
);
    localparam int PW = CLKPERUSEC > 1 ? $clog2(CLKPERUSEC) : 1;
    logic [PW-1:0] pre;
    assign tick = pre == PW'(CLKPERUSEC - 1);
    assign hit = count >= limit;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
            count <= '0;
        end else if (clr) begin
            pre <= '0;
            count <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            count <= tick ? count + 1'b1 : count;
        end
    end
endmodule

// File: rtl/xe1ap_reader.sv
// xe1ap_reader: polls an XE-1AP joystick (REQ strobe, TRG1/TRG2-framed nibbles)
// and publishes an atomically updated report of buttons and three analog channels.
module xe1ap_reader
    import xe1ap_pkg::*;
#(
    parameter int CLKPERUSEC = 50,
    parameter int REQ_LOW_US = 4,
    parameter int TIMEOUT_US = 200,
    parameter int SAMPLE_DLY = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       start,
    input  logic       trg1_in,
    input  logic       trg2_in,
    input  logic [3:0] data_in,
    output logic       req,
    output logic       busy,
    output logic       valid,
    output logic       timeout,
    output logic       frame_err,
    output logic [7:0] buttons,
    output logic [3:0] buttons_ab,
    output logic [7:0] ch0,
    output logic [7:0] ch1,
    output logic [7:0] ch2
);
    localparam int UW = $clog2(TIMEOUT_US + REQ_LOW_US + 2);
    localparam int DW = SAMPLE_DLY > 1 ? $clog2(SAMPLE_DLY) : 1;
    state_t state, state_next;
    logic [5:0] sync1, sync2;
    logic trg2_d, trg1_last, phase_err, us_tick, us_hit, fall, smp_done, frame_ok;
    logic [UW-1:0] us_cnt;
    logic [DW-1:0] dly;
    logic [3:0] idx;
    logic [4*NIBBLES-1:0] stg;
    assign fall = trg2_d & ~sync2[4];
    assign smp_done = dly == DW'(SAMPLE_DLY - 1);
    assign frame_ok = nib(stg, N_END) == 4'hF && !phase_err;
    assign req = state != REQ_LOW;
    assign busy = state != IDLE;
    xe1ap_usec_timer #(.CLKPERUSEC(CLKPERUSEC), .W(UW)) u_timer (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .clr(state_next != state),
        .limit(UW'(TIMEOUT_US)),
        .tick(us_tick),
        .count(us_cnt),
        .hit(us_hit)
    );
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? REQ_LOW : IDLE;
            REQ_LOW: state_next = (us_tick && us_cnt == UW'(REQ_LOW_US - 1)) ? WAIT : REQ_LOW;
            WAIT:    state_next = fall ? SAMPLE : us_hit ? IDLE : WAIT;
            SAMPLE:  state_next = !smp_done ? SAMPLE : idx == 4'(N_END) ? CHECK : WAIT;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    // sync vectors are {trg1, trg2, data[3:0]}
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sync1 <= '1;
            sync2 <= '1;
            trg2_d <= 1'b1;
            trg1_last <= 1'b0;
            phase_err <= 1'b0;
            dly <= '0;
            idx <= '0;
            stg <= '0;
            valid <= 1'b0;
            timeout <= 1'b0;
            frame_err <= 1'b0;
            buttons <= '0;
            buttons_ab <= '0;
            ch0 <= 8'h80;
            ch1 <= 8'h80;
            ch2 <= 8'h80;
        end else begin
            state <= state_next;
            sync1 <= {trg1_in, trg2_in, data_in};
            sync2 <= sync1;
            trg2_d <= sync2[4];
            valid <= state == CHECK && frame_ok;
            frame_err <= state == CHECK && !frame_ok;
            timeout <= state == WAIT && !fall && us_hit;
            if (state == REQ_LOW) begin
                idx <= '0;
                phase_err <= 1'b0;
            end
            // every nibble must arrive in the opposite TRG1 phase to the previous one
            if (state == WAIT && fall) begin
                dly <= '0;
                trg1_last <= sync2[5];
                if (idx != '0 && sync2[5] == trg1_last) phase_err <= 1'b1;
            end
            if (state == SAMPLE) begin
                dly <= dly + 1'b1;
                if (smp_done) begin
                    stg[{idx, 2'b00} +: 4] <= sync2[3:0];
                    idx <= idx + 1'b1;
                end
            end
            if (state == CHECK && frame_ok) begin
                buttons <= ~{nib(stg, N_BTN1), nib(stg, N_BTN2)};
                buttons_ab <= ~nib(stg, N_AB);
                ch0 <= {nib(stg, N_CH0H), nib(stg, N_CH0L)};
                ch1 <= {nib(stg, N_CH1H), nib(stg, N_CH1L)};
                ch2 <= {nib(stg, N_CH2H), nib(stg, N_CH2L)};
            end
        end
    end
endmodule

// File: tb/tb_xe1ap_reader.sv
// tb_xe1ap_reader: device BFM driving table-driven XE-1AP frames into the reader,
// with a report scoreboard and hand-written timeout / abort / repeated-start cases.
`timescale 1ns/1ps
module tb_xe1ap_reader;
    localparam int CPU = 10;
    typedef logic [35:0] rep_t;
    typedef struct {
        logic [47:0] nib;
        int gap;
        int skew;
        int t1x;
        bit ok;
        rep_t exp;
    } vec_t;
    logic clk_sys = 1'b0, reset_n = 1'b0, start = 1'b0, trg1_in = 1'b1, trg2_in = 1'b1;
    logic [3:0] data_in = 4'hF;
    logic req, busy, valid, timeout, frame_err;
    logic [7:0] buttons, ch0, ch1, ch2;
    logic [3:0] buttons_ab;
    xe1ap_reader #(.CLKPERUSEC(CPU)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .trg1_in(trg1_in),
        .trg2_in(trg2_in), .data_in(data_in), .req(req), .busy(busy), .valid(valid),
        .timeout(timeout), .frame_err(frame_err), .buttons(buttons), .buttons_ab(buttons_ab),
        .ch0(ch0), .ch1(ch1), .ch2(ch2)
    );
    always #5 clk_sys = ~clk_sys;
    int total = 0, bad = 0;
    int cyc = 0, n_valid = 0, n_ferr = 0, n_to = 0, n_reqfall = 0;
    int req_fall_cyc = 0, req_rise_cyc = 0, req_low_w = 0, to_delay = 0;
    logic req_q = 1'b1;
    rep_t sb[$];
    rep_t cur, rst_rep;
    vec_t vt[5];
    function automatic rep_t rep();
        return {buttons, buttons_ab, ch0, ch1, ch2};
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic wait_us(input int n);
        repeat (n * CPU) @(negedge clk_sys);
    endtask
    task automatic pulse_start();
        @(negedge clk_sys);
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
    endtask
    always @(negedge clk_sys) begin
        rep_t e;
        cyc++;
        if (req_q && !req) begin n_reqfall++; req_fall_cyc = cyc; end
        if (!req_q && req) begin req_rise_cyc = cyc; req_low_w = cyc - req_fall_cyc; end
        req_q = req;
        if (timeout) begin n_to++; to_delay = cyc - req_rise_cyc; end
        if (frame_err) n_ferr++;
        if (valid) begin
            n_valid++;
            if (sb.size() == 0) chk("valid_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                chk("valid_report", rep(), e);
            end
        end
    end
    task automatic send_frame(input vec_t v, input int abort_at, input int extra);
        int v0, e0, r0;
        bit ok;
        logic [3:0] n;
        logic [47:0] nb;
        v0 = n_valid; e0 = n_ferr; r0 = n_reqfall; nb = v.nib;
        pulse_start();
        for (int k = 0; k < extra; k++) begin
            repeat (3) @(negedge clk_sys);
            pulse_start();
        end
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk_sys);
            ok = n_reqfall > r0 && req === 1'b1;
        end
        chk("req_pulse_seen", ok, 1);
        if (!ok) return;
        chk("req_low_width", req_low_w >= 4 * CPU - 2 && req_low_w <= 4 * CPU + 2, 1);
        if (extra > 0) pulse_start();
        if (abort_at == 0 && v.ok) sb.push_back(v.exp);
        wait_us(68);
        for (int i = 0; i < 12; i++) begin
            n = nb[47 - 4 * i -: 4];
            trg1_in = i[0] ^ (v.t1x != 0 && i + 1 >= v.t1x);
            data_in = v.skew != 0 ? ~n : n;
            repeat (2) @(negedge clk_sys);
            trg2_in = 1'b0;
            if (v.skew != 0) begin
                repeat (v.skew) @(posedge clk_sys);
                #1 data_in = n;
            end
            wait_us(2);
            trg2_in = 1'b1;
            if (abort_at == i + 1) begin
                @(negedge clk_sys);
                #2 reset_n = 1'b0;
                #1;
                chk("abort_req", req, 1);
                chk("abort_busy", busy, 0);
                chk("abort_report", rep(), rst_rep);
                cur = rst_rep;
                sb.delete();
                trg1_in = 1'b1;
                data_in = 4'hF;
                repeat (3) @(negedge clk_sys);
                reset_n = 1'b1;
                repeat (3) @(negedge clk_sys);
                return;
            end
            if (i < 11) wait_us((v.gap != 0 ? v.gap : (i[0] ? 50 : 17)) - 2);
        end
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk_sys);
            ok = busy === 1'b0;
        end
        chk("frame_end_busy", ok, 1);
        repeat (3) @(negedge clk_sys);
        chk("valid_count", n_valid - v0, v.ok);
        chk("frame_err_count", n_ferr - e0, !v.ok);
        chk("req_pulses", n_reqfall - r0, 1);
        if (v.ok) cur = v.exp;
        chk("report_after", rep(), cur);
        chk("scoreboard_drained", sb.size(), 0);
    endtask
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int t0, v0;
        bit ok;
        rst_rep = {8'h00, 4'h0, 8'h80, 8'h80, 8'h80};
        cur = rst_rep;
        vt[0] = '{48'h331A702BF0FF, 0, 0, 0, 1'b1, {8'hCC, 4'h0, 8'h12, 8'hAB, 8'h7F}};
        vt[1] = '{48'hF00F850F0A5F, 10, 2, 0, 1'b1, {8'h0F, 4'hA, 8'h00, 8'hFF, 8'h80}};
        vt[2] = '{48'h331A702BF0FE, 0, 0, 0, 1'b0, 36'h0};
        vt[3] = '{48'h0F56C0A9300F, 0, 2, 0, 1'b1, {8'hF0, 4'hF, 8'h5A, 8'h69, 8'hC3}};
        vt[4] = '{48'h331A702BF0FF, 0, 0, 5, 1'b0, 36'h0};
        repeat (5) @(negedge clk_sys);
        chk("rst_req", req, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {valid, timeout, frame_err}, 0);
        chk("rst_report", rep(), rst_rep);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        t0 = n_to; v0 = n_valid;
        pulse_start();
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk_sys);
            ok = n_to > t0;
        end
        chk("timeout_seen", ok, 1);
        chk("timeout_delay", to_delay >= 199 * CPU && to_delay <= 201 * CPU, 1);
        repeat (3) @(negedge clk_sys);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_valid", n_valid - v0, 0);
        chk("timeout_report", rep(), rst_rep);
        for (int i = 0; i < 5; i++) send_frame(vt[i], 0, i == 0 ? 4 : 0);
        send_frame(vt[3], 6, 0);
        send_frame(vt[1], 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
